// File: rtl/echo_tap_scheduler.sv
// Shares one single-port sample BRAM between mic capture and a multi-tap echo playback.
// Each accepted sample triggers either one write (record) or up to TAP_COUNT tap reads.
//
// state     | meaning
// S_IDLE    | waiting for an audio strobe
// S_WRITE   | write issued on previous edge; retire it
// S_READ    | issuing tap addresses, one per cycle
// S_COLLECT | waiting out read latency, capturing taps, then publishing outputs
module echo_tap_scheduler #(
  parameter int ADDR_W       = 16,
  parameter int MEM_DEPTH    = 65536,
  parameter int TAP_COUNT    = 3,
  parameter int TAP_SPACING  = 1500,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              record_in,
  input  logic              audio_valid_in,
  input  logic [7:0]        audio_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [7:0]        mem_din_out,
  input  logic [7:0]        mem_dout_in,
  output logic [7:0]        single_out,
  output logic [7:0]        echo_out,
  output logic              busy_out
);

  localparam int PW    = ADDR_W + 1;
  localparam int TOTAL = TAP_COUNT + READ_LATENCY + 1;
  localparam int TW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_COLLECT} state_t;

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr, r_record_len;
  logic               r_rec_prev;
  logic [TW-1:0]      r_timer;
  logic [3:0]         r_tap_ok;
  logic signed [9:0]  r_acc;
  logic [7:0]         r_tap0;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_we;
  logic [7:0]         r_mem_din;
  logic [7:0]         r_single, r_echo;
  logic               r_busy;

  logic               w_accept, w_rec, w_rise, w_play, w_fall, w_wr_ok;
  logic [PW-1:0]      w_len, w_rd_start, w_wr_addr, w_rd_next;
  logic [3:0]         w_tap_ok;
  logic [TW-1:0]      w_cyc;
  logic [1:0]         w_cap_k;
  logic               w_issue, w_capture, w_last;
  logic signed [9:0]  w_tap_val, w_sum;
  logic [7:0]         w_sat;

  assign mem_addr_out = r_mem_addr;
  assign mem_we_out   = r_mem_we;
  assign mem_din_out  = r_mem_din;
  assign single_out   = r_single;
  assign echo_out     = r_echo;
  assign busy_out     = r_busy;

  always_comb begin
    w_accept   = (r_state == S_IDLE) && audio_valid_in;
    w_rec      = w_accept && record_in;
    w_rise     = w_rec && !r_rec_prev;
    w_play     = w_accept && !record_in;
    w_fall     = w_play && r_rec_prev;
    w_len      = w_fall ? r_wr_ptr : r_record_len;
    w_rd_start = w_fall ? '0 : r_rd_ptr;
    w_wr_addr  = w_rise ? '0 : r_wr_ptr;
    w_wr_ok    = 32'(w_wr_addr) < 32'(MEM_DEPTH);
    w_rd_next  = (r_rd_ptr + PW'(1) == r_record_len) ? '0 : r_rd_ptr + PW'(1);
    // taps reaching before address 0 are masked rather than wrapped
    w_tap_ok = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < TAP_COUNT && 32'(w_rd_start) >= 32'(k * TAP_SPACING)) w_tap_ok[k] = 1'b1;
    end
    // w_cyc counts cycles since acceptance (1 on the first busy cycle)
    w_cyc     = TW'(TOTAL) - r_timer;
    w_issue   = (r_state == S_READ) && (32'(w_cyc) < 32'(TAP_COUNT));
    w_capture = (r_state == S_READ || r_state == S_COLLECT) &&
                (w_cyc >= TW'(READ_LATENCY + 1)) && (w_cyc <= TW'(TAP_COUNT + READ_LATENCY));
    w_last    = w_capture && (w_cyc == TW'(TAP_COUNT + READ_LATENCY));
    w_cap_k   = 2'(w_cyc - TW'(READ_LATENCY + 1));
    w_tap_val = r_tap_ok[w_cap_k] ? ($signed({{2{mem_dout_in[7]}}, mem_dout_in}) >>> w_cap_k) : 10'sd0;
    w_sum     = ((w_cap_k == 2'd0) ? 10'sd0 : r_acc) + w_tap_val;
    if (w_sum > 10'sd127)       w_sat = 8'h7f;
    else if (w_sum < -10'sd128) w_sat = 8'h80;
    else                        w_sat = w_sum[7:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rec)                      w_state_nxt = S_WRITE;
        else if (w_play && w_len != '0) w_state_nxt = S_READ;
      end
      S_WRITE:   w_state_nxt = S_IDLE;
      S_READ:    if (32'(w_cyc) >= 32'(TAP_COUNT - 1)) w_state_nxt = S_COLLECT;
      S_COLLECT: if (r_timer == '0) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_record_len <= '0;
      r_rec_prev   <= 1'b0;
      r_timer      <= '0;
      r_tap_ok     <= '0;
      r_acc        <= '0;
      r_tap0       <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_din    <= '0;
      r_single     <= '0;
      r_echo       <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if ((r_state == S_READ || r_state == S_COLLECT) && r_timer != '0)
        r_timer <= r_timer - TW'(1);

      if (w_rec) begin
        r_rec_prev <= 1'b1;
        r_single   <= '0;
        r_echo     <= '0;
        r_busy     <= 1'b1;
        if (w_wr_ok) begin
          r_mem_we   <= 1'b1;
          r_mem_addr <= ADDR_W'(w_wr_addr);
          r_mem_din  <= audio_in;
          r_wr_ptr   <= w_wr_addr + PW'(1);
        end else begin
          r_wr_ptr   <= w_wr_addr;
        end
      end else if (w_play) begin
        r_rec_prev   <= 1'b0;
        r_record_len <= w_len;
        r_rd_ptr     <= w_rd_start;
        if (w_len == '0) begin
          r_single <= '0;
          r_echo   <= '0;
        end else begin
          r_busy     <= 1'b1;
          r_timer    <= TW'(TOTAL - 1);
          r_tap_ok   <= w_tap_ok;
          r_mem_addr <= ADDR_W'(w_rd_start);
        end
      end

      if (r_state == S_WRITE) r_busy <= 1'b0;

      if (w_issue && r_tap_ok[2'(w_cyc)])
        r_mem_addr <= ADDR_W'(r_rd_ptr - PW'(w_cyc * TAP_SPACING));

      if (w_capture) begin
        r_acc <= w_sum;
        if (w_cap_k == 2'd0) r_tap0 <= mem_dout_in;
      end

      if (w_last) begin
        r_single <= (w_cap_k == 2'd0) ? mem_dout_in : r_tap0;
        r_echo   <= w_sat;
        r_rd_ptr <= w_rd_next;
      end

      if (r_state == S_COLLECT && r_timer == '0) r_busy <= 1'b0;
    end
  end

endmodule

// File: doc/echo_tap_scheduler.md
# echo_tap_scheduler

Time-multiplexes one single-port sample BRAM between microphone capture and a multi-tap playback read sequence. Runs in the audio clock domain (clk_m, 98.3 MHz) between the PDM decimator and the output source select ahead of volume_control. Per accepted audio sample it performs one write (recording) or up to TAP_COUNT reads (playback). It produces a dry playback stream and a saturated, attenuated echo stream.

## Interface
Parameters:
- ADDR_W, 16: BRAM address width.
- MEM_DEPTH, 65536: usable samples; must be ≤ 2**ADDR_W.
- TAP_COUNT, 3: read taps per playback sample (1..4).
- TAP_SPACING, 1500: delay in samples between successive taps (125 ms at 12 kHz).
- READ_LATENCY, 2: BRAM address-to-data latency in cycles.

Ports:
- clk_in  input  1  system clock (clk_m).
- rst_in  input  1  synchronous reset, active-high.
- record_in  input  1  debounced record request.
- audio_valid_in  input  1  single-cycle sample strobe.
- audio_in  input  8  signed mic sample.
- mem_addr_out  output  ADDR_W  BRAM address (registered).
- mem_we_out  output  1  BRAM write enable (registered).
- mem_din_out  output  8  BRAM write data (registered).
- mem_dout_in  input  8  BRAM read data.
- single_out  output  8  signed dry playback sample.
- echo_out  output  8  signed echo-mixed playback sample.
- busy_out  output  1  high while a sequence is in progress.

## Operation
- States: IDLE, WRITE, READ, COLLECT.
- In IDLE, audio_valid_in is accepted. record_in is sampled only at acceptance and compared with the previous sampled value (rec_prev).
- Record rising edge (rec_prev=0, record_in=1):
  - wr_ptr←0, then WRITE.
- Record held:
  - WRITE with audio_in at wr_ptr; wr_ptr++.
  - When wr_ptr = MEM_DEPTH, the write is skipped (mem_we_out stays 0) and the sample is dropped.
  - single_out and echo_out are held at 0 while recording.
- Record falling edge:
  - record_len←wr_ptr; rd_ptr←0.
  - The same sample starts a playback sequence.
- Playback (record_in=0):
  - If record_len=0, no reads are issued and both outputs are 0.
  - Otherwise READ issues tap k (k=0..TAP_COUNT-1) at address rd_ptr − k·TAP_SPACING.
  - A tap whose address would be negative issues no read and contributes 0. Taps never wrap.
  - COLLECT captures each tap READ_LATENCY cycles after its address is issued.
  - After the last tap: rd_ptr←(rd_ptr+1 = record_len) ? 0 : rd_ptr+1.
- Arithmetic:
  - single_out = tap0.
  - echo_out = Σ (tap_k >>> k), accumulated in 10-bit signed.
  - The sum saturates to [−128, 127].
- audio_valid_in arriving while busy_out=1 is ignored. That sample is lost and pointers do not advance.
- Reset clears all outputs, busy_out, mem_we_out, mem_addr_out, mem_din_out, wr_ptr, rd_ptr, record_len and rec_prev to 0, and forces IDLE.
  - Reset mid-sequence aborts the sequence; outputs keep their reset values.

## Timing
- T = cycle audio_valid_in is sampled high in IDLE.
- Write sequence:
  - mem_we_out=1, mem_addr_out=wr_ptr, mem_din_out=audio_in at T+1.
  - mem_we_out=0 from T+2.
  - busy_out=1 at T+1 only.
- Read sequence:
  - Tap k address is on mem_addr_out at T+1+k.
  - Tap k data is sampled at T+1+k+READ_LATENCY.
  - single_out and echo_out update together at T+TAP_COUNT+READ_LATENCY+1 (T+6 at defaults) and hold until the next update.
  - busy_out=1 from T+1 through the update cycle; IDLE again on the following cycle.
- Empty playback (record_len=0): outputs are forced to 0 at T+1; busy_out stays low.
- mem_we_out is never high during READ or COLLECT.

## Test plan
- Reset: assert rst_in mid-read-sequence → next cycle all outputs 0, busy_out 0; a subsequent audio_valid_in with record_in=0 and record_len=0 produces no reads.
- Record/playback (TAP_COUNT=1):
  - Record samples 10, 20, 30, 40 → writes to addresses 0..3; release record_in.
  - Five playback strobes → single_out 10, 20, 30, 40, 10 (wrap).
- Echo mix (TAP_COUNT=3, TAP_SPACING=2, memory 10, 20, 30, 40, 50):
  - rd_ptr=2 → echo_out 35 (30+(10>>>1); tap2 skipped).
  - rd_ptr=4 → echo_out 67 (50+15+2).
- Saturation:
  - All-127 memory with three valid taps → echo_out 127.
  - All −128 memory → echo_out −128.
- Full memory (MEM_DEPTH=8): record 10 samples → exactly 8 writes (addresses 0..7); record_len=8; playback wraps after address 7.
- Busy drop: second audio_valid_in at T+3 during a read sequence → ignored; rd_ptr advances by exactly 1; outputs update once at T+6.
